// File: rtl/qu_rob_ctrl.sv
// qu_rob_ctrl: reorder-buffer controller for the Qu out-of-order core.
// Allocates entries in program order, tracks each one through
// PENDING -> EXECUTE -> RETIRED, presents the head for in-order commit and
// flushes the whole buffer when a mispredicted branch commits.
// Optional feature: define QU_ROB_WB_CHECK_EN to enable the sticky
// illegal issue/writeback flag on wb_err_o (tied to 0 otherwise).

package qu_rob_pkg;
  localparam int unsigned ROB_DEPTH         = 8;
  localparam int unsigned ROB_ADDR_WIDTH    = $clog2(ROB_DEPTH);
  localparam int unsigned PHY_RF_ADDR_WIDTH = 6;

  typedef logic [31:0] dest_t;

  typedef enum logic [1:0] {
    ROB_EMPTY   = 2'd0,
    ROB_PENDING = 2'd1,
    ROB_EXECUTE = 2'd2,
    ROB_RETIRED = 2'd3
  } rob_state_t;

  typedef struct packed {
    logic [PHY_RF_ADDR_WIDTH-1:0] phyreg_old;
    dest_t                        dest;
    logic                         store;
    logic                         load;
    logic [31:0]                  value;
    logic                         mispredicted_branch;
    rob_state_t                   state;
  } rob_cell_t;
endpackage

module qu_rob_ctrl
  import qu_rob_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc_valid_i,
  output logic                         alloc_ready_o,
  input  logic [PHY_RF_ADDR_WIDTH-1:0] alloc_phyreg_old_i,
  input  logic [31:0]                  alloc_dest_i,
  input  logic                         alloc_store_i,
  input  logic                         alloc_load_i,
  output logic [AW-1:0]                alloc_addr_o,
  input  logic                         issue_valid_i,
  input  logic [AW-1:0]                issue_addr_i,
  input  logic                         wb_valid_i,
  input  logic [AW-1:0]                wb_addr_i,
  input  logic [31:0]                  wb_value_i,
  input  logic                         wb_mispredict_i,
  output logic                         commit_valid_o,
  input  logic                         commit_ready_i,
  output logic [AW-1:0]                commit_addr_o,
  output logic [$bits(rob_cell_t)-1:0] commit_cell_o,
  output logic                         flush_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [AW:0]                  count_o,
  output logic                         wb_err_o
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  rob_cell_t     cells_q [DEPTH];
  rob_cell_t     cells_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  rob_cell_t     head_cell;
  logic          alloc_hs;
  logic          commit_hs;
  logic          issue_ok;
  logic          wb_ok;

  assign head_cell      = cells_q[head_q];
  assign full_o         = (count_q == FULL_COUNT);
  assign empty_o        = (count_q == '0);
  assign count_o        = count_q;
  assign alloc_addr_o   = tail_q;
  assign commit_addr_o  = head_q;
  assign commit_cell_o  = head_cell;
  assign commit_valid_o = (head_cell.state == ROB_RETIRED) && !empty_o;
  assign commit_hs      = commit_valid_o && commit_ready_i;
  assign flush_o        = commit_hs && head_cell.mispredicted_branch;
  assign alloc_ready_o  = !full_o && !flush_o;
  assign alloc_hs       = alloc_valid_i && alloc_ready_o;
  assign issue_ok       = issue_valid_i && (cells_q[issue_addr_i].state == ROB_PENDING);
  assign wb_ok          = wb_valid_i && ((cells_q[wb_addr_i].state == ROB_PENDING) ||
                                         (cells_q[wb_addr_i].state == ROB_EXECUTE));

  // Per-entry next state; later updates override earlier ones so writeback
  // beats issue, and a freshly allocated tail entry overrides everything.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cells_d[i] = cells_q[i];
      if (flush_o) begin
        cells_d[i] = '0;
      end else begin
        if (issue_ok && (issue_addr_i == AW'(i))) begin
          cells_d[i].state = ROB_EXECUTE;
        end
        if (wb_ok && (wb_addr_i == AW'(i))) begin
          cells_d[i].value               = wb_value_i;
          cells_d[i].mispredicted_branch = wb_mispredict_i;
          cells_d[i].state               = ROB_RETIRED;
        end
        if (commit_hs && (head_q == AW'(i))) begin
          cells_d[i].state = ROB_EMPTY;
        end
        if (alloc_hs && (tail_q == AW'(i))) begin
          cells_d[i]            = '0;
          cells_d[i].phyreg_old = alloc_phyreg_old_i;
          cells_d[i].dest       = alloc_dest_i;
          cells_d[i].store      = alloc_store_i;
          cells_d[i].load       = alloc_load_i;
          cells_d[i].state      = ROB_PENDING;
        end
      end
    end
  end

  // Pointer and occupancy next state; a flush returns everything to zero.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_o) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commit_hs) head_d = head_q + AW'(1);
      if (alloc_hs)  tail_d = tail_q + AW'(1);
      case ({alloc_hs, commit_hs})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Entry storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cells_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cells_q[i] <= cells_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef QU_ROB_WB_CHECK_EN
  logic wb_err_q, wb_err_d;
  logic illegal_op;

  assign illegal_op = (wb_valid_i && !wb_ok) || (issue_valid_i && !issue_ok);
  assign wb_err_d   = wb_err_q || illegal_op;
  assign wb_err_o   = wb_err_q;

  // Sticky record of any issue/writeback aimed at an entry in the wrong state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_err_q <= 1'b0;
    end else begin
      wb_err_q <= wb_err_d;
    end
  end
`else
  assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_qu_rob_ctrl.sv
// Self-checking bench for qu_rob_ctrl: directed scenarios plus a randomized
// run compared against a queue-based model of the in-flight instructions.
module tb_qu_rob_ctrl;
  import qu_rob_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
`ifdef QU_ROB_WB_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         alloc_valid_i;
  logic                         alloc_ready_o;
  logic [PHY_RF_ADDR_WIDTH-1:0] alloc_phyreg_old_i;
  logic [31:0]                  alloc_dest_i;
  logic                         alloc_store_i;
  logic                         alloc_load_i;
  logic [AW-1:0]                alloc_addr_o;
  logic                         issue_valid_i;
  logic [AW-1:0]                issue_addr_i;
  logic                         wb_valid_i;
  logic [AW-1:0]                wb_addr_i;
  logic [31:0]                  wb_value_i;
  logic                         wb_mispredict_i;
  logic                         commit_valid_o;
  logic                         commit_ready_i;
  logic [AW-1:0]                commit_addr_o;
  rob_cell_t                    commit_cell_o;
  logic                         flush_o;
  logic                         full_o;
  logic                         empty_o;
  logic [AW:0]                  count_o;
  logic                         wb_err_o;

  int tests = 0;
  int fails = 0;

  // Model: in-flight instructions in program order, oldest first.
  typedef struct {
    logic [AW-1:0] tag;
    logic [5:0]    phy;
    logic [31:0]   dest;
    logic          st;
    logic          ld;
    logic [31:0]   val;
    logic          misp;
    int            stage;   // 0 waiting, 1 issued, 2 result written
  } ment_t;
  ment_t mq[$];

  qu_rob_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_phyreg_old_i(alloc_phyreg_old_i), .alloc_dest_i(alloc_dest_i),
    .alloc_store_i(alloc_store_i), .alloc_load_i(alloc_load_i),
    .alloc_addr_o(alloc_addr_o),
    .issue_valid_i(issue_valid_i), .issue_addr_i(issue_addr_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_value_i(wb_value_i),
    .wb_mispredict_i(wb_mispredict_i),
    .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
    .commit_addr_o(commit_addr_o), .commit_cell_o(commit_cell_o),
    .flush_o(flush_o), .full_o(full_o), .empty_o(empty_o),
    .count_o(count_o), .wb_err_o(wb_err_o)
  );

  always #5 clk = ~clk;

  task automatic idle();
    alloc_valid_i = 0; alloc_phyreg_old_i = '0; alloc_dest_i = '0;
    alloc_store_i = 0; alloc_load_i = 0;
    issue_valid_i = 0; issue_addr_i = '0;
    wb_valid_i = 0; wb_addr_i = '0; wb_value_i = '0; wb_mispredict_i = 0;
    commit_ready_i = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid_i = 1; alloc_dest_i = 32'hA0 + i; alloc_phyreg_old_i = 6'(10 + i);
      alloc_store_i = (i == 1); alloc_load_i = (i == 2);
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count_o); end
    tests++; if (empty_o !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty_o); end
    tests++; if (full_o !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full_o); end
    tests++; if (alloc_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", alloc_ready_o); end
    tests++; if (commit_valid_o !== 1'b0) begin fails++; $display("FAIL reset_cvalid got %b exp 0", commit_valid_o); end
    tests++; if (flush_o !== 1'b0) begin fails++; $display("FAIL reset_flush got %b exp 0", flush_o); end
    tests++; if (wb_err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", wb_err_o); end
    tests++; if (alloc_addr_o !== 3'd0 || commit_addr_o !== 3'd0) begin
      fails++; $display("FAIL reset_ptrs got %0d/%0d exp 0/0", alloc_addr_o, commit_addr_o); end
    tests++; if (commit_cell_o !== '0) begin fails++; $display("FAIL reset_cell got %h exp 0", commit_cell_o); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc_valid_i = 1; alloc_dest_i = 32'h100 + i; alloc_phyreg_old_i = 6'(i);
      #1;
      tests++; if (alloc_addr_o !== 3'(i) || alloc_ready_o !== 1'b1) begin
        fails++; $display("FAIL fill_addr got %0d rdy %b exp %0d rdy 1", alloc_addr_o, alloc_ready_o, i); end
      tick();
    end
    alloc_valid_i = 0; #1;
    tests++; if (full_o !== 1'b1 || alloc_ready_o !== 1'b0 || count_o !== 4'd8) begin
      fails++; $display("FAIL fill_full got full %b rdy %b cnt %0d exp 1 0 8", full_o, alloc_ready_o, count_o); end
    alloc_valid_i = 1; tick(); alloc_valid_i = 0; #1;
    tests++; if (count_o !== 4'd8 || alloc_addr_o !== 3'd0) begin
      fails++; $display("FAIL fill_ninth got cnt %0d tail %0d exp 8 0", count_o, alloc_addr_o); end
  endtask

  task automatic test_ooo_wb();
    logic [31:0] vals [3];
    rob_cell_t ec;
    vals[0] = 32'hDEADBEEF; vals[1] = 32'h11111111; vals[2] = 32'h22222222;
    do_reset();
    alloc_n(3);
    wb_valid_i = 1; wb_addr_i = 3'd2; wb_value_i = vals[2]; #1;
    tests++; if (commit_valid_o !== 1'b0) begin fails++; $display("FAIL ooo_cv_before got %b exp 0", commit_valid_o); end
    tick();
    wb_addr_i = 3'd0; wb_value_i = vals[0]; #1;
    tests++; if (commit_valid_o !== 1'b0) begin fails++; $display("FAIL ooo_cv_tag2only got %b exp 0", commit_valid_o); end
    tick();
    wb_valid_i = 0; #1;
    tests++; if (commit_valid_o !== 1'b1 || commit_addr_o !== 3'd0) begin
      fails++; $display("FAIL ooo_cv_tag0 got %b addr %0d exp 1 0", commit_valid_o, commit_addr_o); end
    tick();
    tests++; if (commit_valid_o !== 1'b1 || commit_cell_o.value !== vals[0]) begin
      fails++; $display("FAIL ooo_hold got %b val %h exp 1 %h", commit_valid_o, commit_cell_o.value, vals[0]); end
    wb_valid_i = 1; wb_addr_i = 3'd1; wb_value_i = vals[1]; tick(); wb_valid_i = 0;
    commit_ready_i = 1;
    for (int k = 0; k < 3; k++) begin
      ec = '0; ec.phyreg_old = 6'(10 + k); ec.dest = 32'hA0 + k; ec.store = (k == 1); ec.load = (k == 2);
      ec.value = vals[k]; ec.state = ROB_RETIRED;
      #1;
      tests++; if (commit_valid_o !== 1'b1 || commit_addr_o !== 3'(k) || commit_cell_o !== ec) begin
        fails++; $display("FAIL ooo_commit%0d got v%b a%0d cell %h exp v1 a%0d cell %h", k, commit_valid_o, commit_addr_o, commit_cell_o, k, ec); end
      tick();
    end
    commit_ready_i = 0; #1;
    tests++; if (empty_o !== 1'b1 || commit_valid_o !== 1'b0) begin
      fails++; $display("FAIL ooo_empty got e%b cv%b exp e1 cv0", empty_o, commit_valid_o); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_n(4);
    for (int t = 0; t < 4; t++) begin
      wb_valid_i = 1; wb_addr_i = 3'(t); wb_value_i = 32'h5000 + t; wb_mispredict_i = (t == 1);
      tick();
    end
    idle();
    commit_ready_i = 1; #1;
    tests++; if (flush_o !== 1'b0 || commit_valid_o !== 1'b1 || commit_addr_o !== 3'd0) begin
      fails++; $display("FAIL flush_c0 got f%b cv%b a%0d exp f0 cv1 a0", flush_o, commit_valid_o, commit_addr_o); end
    tick();
    alloc_valid_i = 1; alloc_dest_i = 32'h77; #1;
    tests++; if (flush_o !== 1'b1 || alloc_ready_o !== 1'b0 || commit_addr_o !== 3'd1) begin
      fails++; $display("FAIL flush_c1 got f%b rdy%b a%0d exp f1 rdy0 a1", flush_o, alloc_ready_o, commit_addr_o); end
    tick();
    idle(); #1;
    tests++; if (count_o !== 4'd0 || empty_o !== 1'b1 || alloc_addr_o !== 3'd0 || commit_addr_o !== 3'd0 || commit_valid_o !== 1'b0) begin
      fails++; $display("FAIL flush_after got cnt%0d e%b t%0d h%0d cv%b exp 0 1 0 0 0", count_o, empty_o, alloc_addr_o, commit_addr_o, commit_valid_o); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    alloc_n(8);
    wb_valid_i = 1; wb_addr_i = 3'd0; wb_value_i = 32'h1; tick(); wb_valid_i = 0;
    alloc_valid_i = 1; commit_ready_i = 1; #1;
    tests++; if (alloc_ready_o !== 1'b0 || commit_valid_o !== 1'b1 || count_o !== 4'd8) begin
      fails++; $display("FAIL wrap_full got rdy%b cv%b cnt%0d exp 0 1 8", alloc_ready_o, commit_valid_o, count_o); end
    tick();
    commit_ready_i = 0; #1;
    tests++; if (count_o !== 4'd7 || alloc_ready_o !== 1'b1 || alloc_addr_o !== 3'd0 || commit_addr_o !== 3'd1) begin
      fails++; $display("FAIL wrap_freed got cnt%0d rdy%b t%0d h%0d exp 7 1 0 1", count_o, alloc_ready_o, alloc_addr_o, commit_addr_o); end
    tick();
    alloc_valid_i = 0; #1;
    tests++; if (count_o !== 4'd8 || full_o !== 1'b1 || alloc_addr_o !== 3'd1) begin
      fails++; $display("FAIL wrap_refill got cnt%0d full%b t%0d exp 8 1 1", count_o, full_o, alloc_addr_o); end
  endtask

  task automatic test_wb_empty();
    do_reset();
    wb_valid_i = 1; wb_addr_i = 3'd5; wb_value_i = 32'hBAD0BAD0; wb_mispredict_i = 1;
    tick(); idle(); #1;
    tests++; if (wb_err_o !== CHK || count_o !== 4'd0 || commit_valid_o !== 1'b0) begin
      fails++; $display("FAIL wbe_err got err%b cnt%0d cv%b exp err%b 0 0", wb_err_o, count_o, commit_valid_o, CHK); end
    alloc_n(6);
    for (int t = 0; t < 5; t++) begin
      wb_valid_i = 1; wb_addr_i = 3'(t); wb_value_i = 32'h9000 + t; tick();
    end
    idle();
    commit_ready_i = 1;
    for (int t = 0; t < 5; t++) tick();
    commit_ready_i = 0; #1;
    tests++; if (commit_addr_o !== 3'd5 || commit_valid_o !== 1'b0 || commit_cell_o.state !== ROB_PENDING ||
                 commit_cell_o.value !== 32'd0 || commit_cell_o.mispredicted_branch !== 1'b0) begin
      fails++; $display("FAIL wbe_slot5 got h%0d cv%b st%0d val%h m%b exp 5 0 1 0 0", commit_addr_o, commit_valid_o,
                        commit_cell_o.state, commit_cell_o.value, commit_cell_o.mispredicted_branch); end
    tests++; if (wb_err_o !== CHK) begin fails++; $display("FAIL wbe_sticky got %b exp %b", wb_err_o, CHK); end
  endtask

  function automatic int find_tag(input logic [AW-1:0] t);
    for (int k = 0; k < mq.size(); k++) if (mq[k].tag == t) return k;
    return -1;
  endfunction

  task automatic test_random();
    int mhead, mtail, cnt, ii, wi;
    logic merr, ecv, eflush, eready, ill;
    ment_t me;
    rob_cell_t ec;
    do_reset();
    mq.delete(); mhead = 0; mtail = 0; merr = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      alloc_valid_i = ($urandom_range(0, 9) < 6);
      alloc_phyreg_old_i = 6'($urandom); alloc_dest_i = $urandom;
      alloc_store_i = 1'($urandom); alloc_load_i = 1'($urandom);
      issue_valid_i = 1'($urandom); issue_addr_i = 3'($urandom);
      wb_valid_i = 1'($urandom); wb_addr_i = 3'($urandom); wb_value_i = $urandom;
      wb_mispredict_i = ($urandom_range(0, 15) == 0);
      commit_ready_i = ($urandom_range(0, 9) < 6);
      #1;
      cnt = mq.size();
      ecv = (cnt > 0) && (mq[0].stage == 2);
      eflush = ecv && commit_ready_i && mq[0].misp;
      eready = (cnt < 8) && !eflush;
      tests++; if (count_o !== 4'(cnt) || full_o !== (cnt == 8) || empty_o !== (cnt == 0)) begin
        fails++; $display("FAIL rnd_occ cyc%0d got cnt%0d f%b e%b exp cnt%0d", cyc, count_o, full_o, empty_o, cnt); end
      tests++; if (commit_valid_o !== ecv || flush_o !== eflush || alloc_ready_o !== eready) begin
        fails++; $display("FAIL rnd_hs cyc%0d got cv%b f%b r%b exp cv%b f%b r%b", cyc, commit_valid_o, flush_o, alloc_ready_o, ecv, eflush, eready); end
      tests++; if (alloc_addr_o !== 3'(mtail) || commit_addr_o !== 3'(mhead)) begin
        fails++; $display("FAIL rnd_ptr cyc%0d got t%0d h%0d exp t%0d h%0d", cyc, alloc_addr_o, commit_addr_o, mtail, mhead); end
      tests++; if (wb_err_o !== merr) begin fails++; $display("FAIL rnd_err cyc%0d got %b exp %b", cyc, wb_err_o, merr); end
      if (ecv) begin
        ec = '0; ec.phyreg_old = mq[0].phy; ec.dest = mq[0].dest; ec.store = mq[0].st; ec.load = mq[0].ld;
        ec.value = mq[0].val; ec.mispredicted_branch = mq[0].misp; ec.state = ROB_RETIRED;
        tests++; if (commit_cell_o !== ec) begin
          fails++; $display("FAIL rnd_cell cyc%0d got %h exp %h", cyc, commit_cell_o, ec); end
      end
      ii = find_tag(issue_addr_i);
      wi = find_tag(wb_addr_i);
      ill = (wb_valid_i && (wi < 0 || mq[wi].stage == 2)) || (issue_valid_i && (ii < 0 || mq[ii].stage != 0));
      if (CHK && ill) merr = 1;
      if (eflush) begin
        mq.delete(); mhead = 0; mtail = 0;
      end else begin
        if (issue_valid_i && ii >= 0 && mq[ii].stage == 0) begin me = mq[ii]; me.stage = 1; mq[ii] = me; end
        if (wb_valid_i && wi >= 0 && mq[wi].stage < 2) begin
          me = mq[wi]; me.val = wb_value_i; me.misp = wb_mispredict_i; me.stage = 2; mq[wi] = me;
        end
        if (ecv && commit_ready_i) begin void'(mq.pop_front()); mhead = (mhead + 1) % 8; end
        if (alloc_valid_i && eready) begin
          me.tag = 3'(mtail); me.phy = alloc_phyreg_old_i; me.dest = alloc_dest_i;
          me.st = alloc_store_i; me.ld = alloc_load_i; me.val = '0; me.misp = 0; me.stage = 0;
          mq.push_back(me); mtail = (mtail + 1) % 8;
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_ooo_wb();
    test_flush();
    test_full_wrap();
    test_wb_empty();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
